// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: shared word geometry and packer state encoding
package uart_fifo_pkg;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W = 32;
    localparam int NBYTES_W = 3;
    typedef enum logic {IDLE, FILL} pk_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO whose head entry is held in an output register
// ports: clk, rst_n (async low); wr_en/wr_data push, wr_accept = push taken;
//        rd_valid/rd_data head, rd_ready pops; level = occupancy; full
module sync_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     wr_accept,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr, rptr_n;
    logic [CW-1:0] count_n, remaining;
    logic pop;
    logic [WIDTH-1:0] head_n;
    assign full = level == CW'(DEPTH);
    assign pop = rd_valid && rd_ready;
    assign wr_accept = wr_en && (!full || pop);
    assign rptr_n = rptr + AW'(pop);
    assign count_n = level + CW'(wr_accept) - CW'(pop);
    assign remaining = level - CW'(pop);
    // with nothing left behind the popped head, the incoming word becomes the new head directly
    assign head_n = remaining == '0 ? wr_data : mem[rptr_n];
    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[wptr] <= wr_data;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            level <= '0;
            rd_valid <= 1'b0;
            rd_data <= '0;
        end else begin
            wptr <= wptr + AW'(wr_accept);
            rptr <= rptr_n;
            level <= count_n;
            rd_valid <= count_n != '0;
            rd_data <= count_n != '0 ? head_n : '0;
        end
    end
endmodule

// File: rtl/uart_rx_packer.sv
// uart_rx_packer: packs UART bytes into 32-bit words with idle-timeout flush into a word FIFO
// ports: i_clk, i_rst_n (async low); i_rx_dv/i_rx_byte byte strobe;
//        o_wr_valid/i_wr_ready/o_wr_data/o_wr_nbytes head word handshake;
//        o_fifo_level occupancy; o_overflow sticky drop flag, i_clr_overflow clears it
module uart_rx_packer
    import uart_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT_CYCLES = 8680
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_rx_dv,
    input  logic [7:0]                    i_rx_byte,
    output logic                          o_wr_valid,
    input  logic                          i_wr_ready,
    output logic [WORD_W-1:0]             o_wr_data,
    output logic [NBYTES_W-1:0]           o_wr_nbytes,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_overflow,
    input  logic                          i_clr_overflow
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    pk_state_t state, state_n;
    logic [1:0] idx, idx_n;
    logic [WORD_W-1:0] word_q, word_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic full_word, timeout, push, accept, fifo_full;
    logic [NBYTES_W-1:0] push_nbytes;
    logic [WORD_W-1:0] push_word;
    assign full_word = i_rx_dv && idx == 2'd3;
    // a strobe in the expiry cycle takes priority, so timeout requires no strobe
    assign timeout = state == FILL && !i_rx_dv && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    assign push = full_word || timeout;
    always_comb begin
        word_n = word_q;
        idx_n = idx;
        state_n = state;
        cnt_n = cnt;
        push_word = '0;
        push_nbytes = '0;
        if (i_rx_dv) begin
            word_n[{idx, 3'b000} +: 8] = i_rx_byte;
            idx_n = idx + 2'd1;
            state_n = FILL;
            cnt_n = '0;
        end else if (state == FILL) begin
            cnt_n = cnt + CNT_W'(1);
        end
        if (push) begin
            push_word = word_n;
            push_nbytes = full_word ? NBYTES_W'(WORD_BYTES) : {1'b0, idx};
            word_n = '0;
            idx_n = '0;
            state_n = IDLE;
            cnt_n = '0;
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            idx <= '0;
            word_q <= '0;
            cnt <= '0;
            o_overflow <= 1'b0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            word_q <= word_n;
            cnt <= cnt_n;
            o_overflow <= (o_overflow && !i_clr_overflow) || (push && !accept);
        end
    end
    sync_fifo #(
        .WIDTH(WORD_W + NBYTES_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk(i_clk),
        .rst_n(i_rst_n),
        .wr_en(push),
        .wr_data({push_nbytes, push_word}),
        .wr_accept(accept),
        .rd_ready(i_wr_ready),
        .rd_valid(o_wr_valid),
        .rd_data({o_wr_nbytes, o_wr_data}),
        .level(o_fifo_level),
        .full(fifo_full)
    );
endmodule
